// File: rtl/mips_mc_sequencer_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface mips_mc_sequencer_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       branch_taken;
  logic       irq;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_sel;
  logic       mem_we;
  logic       ir_wr;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       epc_wr;
  logic [4:0] exc_code;
  logic [2:0] state;

  modport master (
    input  op, funct, branch_taken, irq, mem_ack,
    output mem_req, mem_sel, mem_we, ir_wr, pc_wr, pc_src,
           reg_wr, reg_dst, mem_to_reg, epc_wr, exc_code, state
  );

  modport slave (
    output op, funct, branch_taken, irq, mem_ack,
    input  mem_req, mem_sel, mem_we, ir_wr, pc_wr, pc_src,
           reg_wr, reg_dst, mem_to_reg, epc_wr, exc_code, state
  );
endinterface

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack memory,
// bus timeout, and precise exception/interrupt entry through CP0.
module mips_mc_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mips_mc_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_EXC = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_ALU_R, C_JR, C_SYSCALL, C_LW, C_SW, C_BR,
    C_J, C_JAL, C_ALU_I, C_MFC0, C_RSV
  } cls_e;

  state_e             r_state, w_next;
  cls_e               r_cls, w_dec_cls;
  logic [CNT_W-1:0]   r_cnt;
  logic [4:0]         r_exc_code, w_exc_code;
  logic               w_done, w_tmo;

  logic       w_mem_req, w_mem_sel, w_mem_we, w_ir_wr, w_pc_wr, w_reg_wr, w_epc_wr;
  logic [1:0] w_pc_src, w_reg_dst, w_mem_to_reg;

  always_comb begin
    w_dec_cls = C_RSV;
    case (bus.op)
      6'h00: begin
        if (bus.funct == 6'h0C)      w_dec_cls = C_SYSCALL;
        else if (bus.funct == 6'h08) w_dec_cls = C_JR;
        else                         w_dec_cls = C_ALU_R;
      end
      6'h23:        w_dec_cls = C_LW;
      6'h2B:        w_dec_cls = C_SW;
      6'h04, 6'h05: w_dec_cls = C_BR;
      6'h02:        w_dec_cls = C_J;
      6'h03:        w_dec_cls = C_JAL;
      6'h10:        w_dec_cls = C_MFC0;
      default:      if (bus.op[5:3] == 3'b001) w_dec_cls = C_ALU_I;
    endcase
  end

  // Ack on the limit cycle takes priority over the timeout.
  assign w_tmo = w_mem_req && !bus.mem_ack && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next     = r_state;
    w_exc_code = r_exc_code;
    w_done     = 1'b0;
    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack)  w_next = S_DECODE;
        else if (w_tmo) begin w_next = S_EXC; w_exc_code = 5'd6; end
      end
      S_DECODE: begin
        case (w_dec_cls)
          C_SYSCALL:  begin w_next = S_EXC; w_exc_code = 5'd8;  end
          C_RSV:      begin w_next = S_EXC; w_exc_code = 5'd10; end
          C_J, C_JAL: w_done = 1'b1;
          C_MFC0:     w_next = S_WB;
          default:    w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (r_cls)
          C_BR, C_JR: w_done = 1'b1;
          C_LW, C_SW: w_next = S_MEM;
          default:    w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          if (r_cls == C_SW) w_done = 1'b1;
          else               w_next = S_WB;
        end else if (w_tmo) begin
          w_next = S_EXC; w_exc_code = 5'd7;
        end
      end
      S_WB:    w_done = 1'b1;
      S_EXC:   w_next = S_FETCH;
      default: w_next = S_RST;
    endcase
    // Interrupts are taken only at instruction boundaries.
    if (w_done) begin
      if (bus.irq) begin w_next = S_EXC; w_exc_code = 5'd0; end
      else         w_next = S_FETCH;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RST;
      r_cls      <= C_NONE;
      r_cnt      <= '0;
      r_exc_code <= '0;
    end else begin
      r_state    <= w_next;
      r_exc_code <= w_exc_code;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
      if (w_next != r_state)                 r_cnt <= '0;
      else if (w_mem_req && !bus.mem_ack)    r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Outputs decode from state/class; fetch enables follow ack in the same cycle,
  // so they cannot be registered.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_sel    = 1'b0;
    w_mem_we     = 1'b0;
    w_ir_wr      = 1'b0;
    w_pc_wr      = 1'b0;
    w_pc_src     = 2'b00;
    w_reg_wr     = 1'b0;
    w_reg_dst    = 2'b00;
    w_mem_to_reg = 2'b00;
    w_epc_wr     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_ir_wr   = bus.mem_ack;
        w_pc_wr   = bus.mem_ack;
      end
      S_DECODE: begin
        if (w_dec_cls == C_J || w_dec_cls == C_JAL) begin
          w_pc_wr  = 1'b1;
          w_pc_src = 2'b10;
        end
        if (w_dec_cls == C_JAL) begin
          w_reg_wr     = 1'b1;
          w_reg_dst    = 2'b10;
          w_mem_to_reg = 2'b11;
        end
      end
      S_EXEC: begin
        if (r_cls == C_BR) begin
          w_pc_wr  = bus.branch_taken;
          w_pc_src = 2'b01;
        end else if (r_cls == C_JR) begin
          w_pc_wr  = 1'b1;
          w_pc_src = 2'b10;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_sel = 1'b1;
        w_mem_we  = (r_cls == C_SW);
      end
      S_WB: begin
        w_reg_wr     = 1'b1;
        w_reg_dst    = (r_cls == C_ALU_R) ? 2'b01 : 2'b00;
        w_mem_to_reg = (r_cls == C_LW)   ? 2'b01 :
                       (r_cls == C_MFC0) ? 2'b10 : 2'b00;
      end
      S_EXC: begin
        w_epc_wr = 1'b1;
        w_pc_wr  = 1'b1;
        w_pc_src = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_sel    = w_mem_sel;
  assign bus.mem_we     = w_mem_we;
  assign bus.ir_wr      = w_ir_wr;
  assign bus.pc_wr      = w_pc_wr;
  assign bus.pc_src     = w_pc_src;
  assign bus.reg_wr     = w_reg_wr;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.epc_wr     = w_epc_wr;
  assign bus.exc_code   = r_exc_code;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Randomized bench: an instruction-level reference model walks each instruction's phases
// and predicts every cycle's control outputs, state and exception code.
module tb_mips_mc_sequencer;
  localparam int T = 15;

  localparam int K_ALUR = 0, K_JR = 1, K_SYS = 2, K_LW = 3, K_SW = 4, K_BR = 5,
                 K_J = 6, K_JAL = 7, K_ALUI = 8, K_MFC0 = 9, K_RSV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_mc_sequencer_if bus();

  mips_mc_sequencer #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int         n_chk = 0, n_fail = 0, ncyc = 0, irq_pct = 0;
  int         exp_code = 0;
  logic [5:0] cur_op = '0, cur_funct = '0;
  logic       cur_bt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(int st, bit rq, bit sl, bit we, bit irw, bit pcw,
                                     int pcs, bit rw, int rd, int m2r, bit epc);
    logic [2:0] s3 = st[2:0];
    logic [1:0] p2 = pcs[1:0], d2 = rd[1:0], m2 = m2r[1:0];
    return {s3, rq, sl, we, irw, pcw, p2, rw, d2, m2, epc};
  endfunction

  function automatic logic [15:0] got_vec();
    return {bus.state, bus.mem_req, bus.mem_sel, bus.mem_we, bus.ir_wr, bus.pc_wr,
            bus.pc_src, bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.epc_wr};
  endfunction

  function automatic int kind_of(logic [5:0] o, logic [5:0] f);
    if (o == 6'h00)              return (f == 6'h0C) ? K_SYS : (f == 6'h08) ? K_JR : K_ALUR;
    if (o == 6'h23)              return K_LW;
    if (o == 6'h2B)              return K_SW;
    if (o == 6'h04 || o == 6'h05) return K_BR;
    if (o == 6'h02)              return K_J;
    if (o == 6'h03)              return K_JAL;
    if (o == 6'h10)              return K_MFC0;
    if (o >= 6'h08 && o <= 6'h0F) return K_ALUI;
    return K_RSV;
  endfunction

  function automatic bit ri();
    return ($urandom_range(0, 99) < irq_pct);
  endfunction

  function automatic bit ra();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs after the falling edge, then check the settled outputs.
  task automatic cyc(input logic [15:0] exp, input bit ack, input bit iq);
    @(negedge clk);
    bus.op = cur_op; bus.funct = cur_funct; bus.branch_taken = cur_bt;
    bus.mem_ack = ack; bus.irq = iq;
    #1;
    chk($sformatf("out@%0d", ncyc), 32'(got_vec()), 32'(exp));
    chk($sformatf("exc_code@%0d", ncyc), 32'(bus.exc_code), 32'(exp_code));
    ncyc++;
  endtask

  task automatic enter_exc(input int code);
    exp_code = code;
    cyc(mk(6, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1), ra(), ri());
  endtask

  // Completion cycle: irq sampled here redirects to EXC with code 0.
  task automatic done(input logic [15:0] exp, input bit ack, input bit irq_done);
    bit iq = irq_done ? 1'b1 : ri();
    cyc(exp, ack, iq);
    if (iq) enter_exc(0);
  endtask

  task automatic wb(input int rd, input int m2r, input bit irq_done);
    done(mk(5, 0, 0, 0, 0, 0, 0, 1, rd, m2r, 0), ra(), irq_done);
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fd,
                           input int md, input bit bt, input bit irq_done);
    int k = kind_of(o, f);
    logic [15:0] d0 = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    logic [15:0] e0 = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bit sw = (k == K_SW);
    cur_op = o; cur_funct = f; cur_bt = bt;
    for (int i = 0; i < fd && i < T; i++) cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, ri());
    if (fd >= T) begin enter_exc(6); return; end
    cyc(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b1, ri());
    case (k)
      K_SYS:  begin cyc(d0, ra(), ri()); enter_exc(8);  return; end
      K_RSV:  begin cyc(d0, ra(), ri()); enter_exc(10); return; end
      K_J:    begin done(mk(2, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), ra(), irq_done); return; end
      K_JAL:  begin done(mk(2, 0, 0, 0, 0, 1, 2, 1, 2, 3, 0), ra(), irq_done); return; end
      K_MFC0: begin cyc(d0, ra(), ri()); wb(0, 2, irq_done); return; end
      default: cyc(d0, ra(), ri());
    endcase
    case (k)
      K_BR:   begin done(mk(3, 0, 0, 0, 0, bt, 1, 0, 0, 0, 0), ra(), irq_done); return; end
      K_JR:   begin done(mk(3, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), ra(), irq_done); return; end
      K_ALUR: begin cyc(e0, ra(), ri()); wb(1, 0, irq_done); return; end
      K_ALUI: begin cyc(e0, ra(), ri()); wb(0, 0, irq_done); return; end
      default: cyc(e0, ra(), ri());
    endcase
    for (int i = 0; i < md && i < T; i++) cyc(mk(4, 1, 1, sw, 0, 0, 0, 0, 0, 0, 0), 1'b0, ri());
    if (md >= T) begin enter_exc(7); return; end
    if (sw) begin done(mk(4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, irq_done); return; end
    cyc(mk(4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, ri());
    wb(0, 1, irq_done);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_state", 32'(got_vec()), 32'h0);
  endtask

  function automatic int rdly();
    int s = $urandom_range(0, 9);
    if (s < 7)  return $urandom_range(0, 3);
    if (s == 7) return T - 1;
    if (s == 8) return T;
    return T + 2;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] o, f;
    bus.op = '0; bus.funct = '0; bus.branch_taken = 1'b0; bus.irq = 1'b0; bus.mem_ack = 1'b0;
    #23;
    chk("reset_outputs", 32'(got_vec()), 32'h0);
    chk("reset_exc_code", 32'(bus.exc_code), 32'h0);
    release_rst();

    // Directed scenarios.
    run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0);       // addu
    run_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0);       // lw, data ack after 3 waits
    run_instr(6'h00, 6'h21, T, 0, 1'b0, 1'b0);       // fetch timeout -> code 6
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);       // reserved -> code 10
    run_instr(6'h2B, 6'h00, 0, T - 1, 1'b0, 1'b0);   // sw, ack exactly on limit cycle
    run_instr(6'h2B, 6'h00, 0, T, 1'b0, 1'b0);       // sw data timeout -> code 7
    run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b1);       // irq in WB -> code 0
    run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);       // beq not taken
    run_instr(6'h03, 6'h00, 0, 0, 1'b0, 1'b0);       // jal

    // Reset during a data-memory wait.
    cur_op = 6'h23; cur_funct = 6'h00;
    cyc(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    cyc(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_state", 32'(bus.state), 32'h0);
    exp_code = 0;
    release_rst();
    run_instr(6'h09, 6'h00, 0, 0, 1'b0, 1'b0);       // addiu right after reset

    // Randomized instruction stream.
    irq_pct = 8;
    for (int n = 0; n < 400; n++) begin
      f = 6'($urandom);
      case ($urandom_range(0, 9))
        0: o = 6'h00;
        1: begin o = 6'h00; f = 6'h08; end
        2: begin o = 6'h00; f = 6'h0C; end
        3: o = 6'h23;
        4: o = 6'h2B;
        5: o = 6'h04 + 6'($urandom_range(0, 1));
        6: o = 6'h02 + 6'($urandom_range(0, 1));
        7: o = 6'h08 + 6'($urandom_range(0, 7));
        8: o = 6'h10;
        default: o = 6'($urandom);
      endcase
      run_instr(o, f, rdly(), rdly(), ra(), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_mc_sequencer.md
Name: mips_mc_sequencer

Overview:
- Multi-cycle control sequencer for the next-generation MIPS core. It replaces the single-cycle combinational control path with a state machine that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Memory accesses use a req/ack handshake with a parametrised bus timeout.
- It adds precise exception and interrupt entry through CP0 (EPC write, exception code).
- It drives the datapath enables: pc, ir, rf, dm and CP0.

Parameters:
- MEM_TIMEOUT, 15: max cycles mem_req may stay unacknowledged before a bus-error exception (1..255).
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  6  ins[31:26] from IR
- funct  in  6  ins[5:0] from IR
- branch_taken  in  1  comparator result for beq/bne
- irq  in  1  level interrupt request
- mem_ack  in  1  memory completion for the current request
- mem_req  out  1  memory request
- mem_sel  out  1  0 = instruction fetch, 1 = data
- mem_we  out  1  data write (sw)
- ir_wr  out  1  instruction register load
- pc_wr  out  1  PC load
- pc_src  out  2  00 pc+4, 01 branch target, 10 jump/jr target, 11 exception vector
- reg_wr  out  1  register file write
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg  out  2  00 alu, 01 dm, 10 cop0, 11 return addr
- epc_wr  out  1  CP0 EPC/Cause write
- exc_code  out  5  registered cause code
- state  out  3  current state (debug)

Behaviour:
- State encoding: S_RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, EXC=6.
- Reset (rst=0, asynchronous): state=S_RST, exc_code=0, counter=0, class register=0. All outputs are 0 in S_RST.
- Reset release: S_RST -> FETCH on the first clock edge with rst=1.
- Outputs are Moore, decoded from the state plus the registered instruction class. No output depends combinationally on mem_ack, except ir_wr/pc_wr in FETCH.
- FETCH: mem_req=1, mem_sel=0.
  - On mem_ack: ir_wr=1, pc_wr=1, pc_src=00 in the same cycle; next state DECODE.
- DECODE: classify op/funct and register the class. Transitions:
  - R-type (op=0): EXEC.
  - syscall (funct=0x0C): EXC, code 8.
  - lw (0x23) or sw (0x2B): EXEC.
  - beq/bne (0x04/0x05): EXEC.
  - j (0x02): pc_wr=1, pc_src=10; next FETCH.
  - jal (0x03): pc_wr=1, pc_src=10, reg_wr=1, reg_dst=10, mem_to_reg=11; next FETCH.
  - op[5:3]=001 (I-type ALU): EXEC.
  - op=0x10 (cop0): WB.
  - Any other op: EXC, code 10 (reserved instruction).
- EXEC transitions:
  - Branch: pc_wr=branch_taken, pc_src=01; next FETCH.
  - jr (R-type, funct 0x08): pc_wr=1, pc_src=10; next FETCH.
  - lw/sw: next MEM.
  - ALU instructions: next WB.
- MEM: mem_req=1, mem_sel=1, mem_we=1 for sw.
  - On mem_ack: sw -> FETCH; lw -> WB.
- WB: reg_wr=1; next FETCH.
  - reg_dst: 01 for R-type, 00 otherwise.
  - mem_to_reg: 01 for lw, 10 for mfc0, 00 for ALU.
- Timeout counter:
  - Counts cycles with mem_req=1 and mem_ack=0; clears on every state change.
  - When the counter reaches MEM_TIMEOUT with no ack, the next state is EXC.
  - Code is 6 if the timeout occurs in FETCH (instruction bus error), 7 if in MEM (data bus error).
  - ack arriving on the same cycle as the limit: ack wins and there is no exception.
- Completion: an instruction completes on any transition into FETCH from DECODE, EXEC, MEM or WB.
  - If irq=1 on that cycle, the next state is EXC with code 0 instead of FETCH.
  - The completing instruction's write enables still assert in that cycle.
- EXC: epc_wr=1, pc_wr=1, pc_src=11; exc_code is stable; next FETCH.
  - exc_code is loaded on entry to EXC and holds until the next exception.
  - irq is not re-sampled in EXC.
- Latency with ack in the first request cycle:
  - ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch and jr: 3 cycles.
  - j/jal: 2 cycles.
  - Exception entry: +1 cycle.
- Reset mid-operation: immediate return to S_RST; any outstanding mem_req drops the same instant.

Test Plan:
- Reset then release; IR holds addu (op 0, funct 0x21); ack every request -> state sequence 0,1,2,3,5,1; reg_wr=1 with reg_dst=01 only in WB; 4 cycles from FETCH to FETCH.
- lw with data mem_ack delayed 3 cycles -> mem_req/mem_sel=1 held 4 cycles in MEM; then WB with mem_to_reg=01; total 8 cycles.
- Fetch with no mem_ack, MEM_TIMEOUT=15 -> EXC after 15 unacked cycles; exc_code=6; epc_wr=pc_wr=1, pc_src=11 for one cycle; then FETCH.
- Opcode 0x3F -> DECODE -> EXC with code 10; with ack at exactly cycle 15 of a sw -> no exception, sw completes.
- irq=1 asserted during WB of addu -> reg_wr=1 that cycle, next state EXC with code 0; beq with branch_taken=0 -> pc_wr=0 in EXEC.
- rst pulled low during a MEM wait -> mem_req=0 asynchronously, state=0; after release, FETCH occurs 1 cycle later.
